pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline stall and flush controller for the six-stage CPU pipeline (PC, IF, ID, EX, MEM, WB). It collects per-stage stall requests and exception redirects, and drives the shared `stall[5:0]` vector read by every pipeline register, including the IF/ID register. It sequences exception flushes through a small state machine and maintains stall statistics plus a stuck-pipeline watchdog.

## Interface
Parameters:
- `TIMEOUT`, default 1024: consecutive stall-request cycles that trip the watchdog. Legal range 1..65535.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous reset, active-high (`RstEnable` = 1).
- `stallreq_if`  in  1  IF stage waiting on instruction fetch.
- `stallreq_id`  in  1  ID stage load-use hazard.
- `stallreq_ex`  in  1  EX stage multi-cycle operation (mul/div) busy.
- `stallreq_mem`  in  1  MEM stage waiting on data memory.
- `excp_req`  in  1  exception or redirect reported by MEM.
- `excp_pc`  in  32  handler or redirect target, valid with `excp_req`.
- `stall`  out  6  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB. 1 = `Stop`.
- `flush`  out  1  clear all pipeline registers this cycle.
- `new_pc`  out  32  PC to load while `flush` = 1.
- `stall_cycles`  out  32  saturating count of cycles with `stall` != 0.
- `stall_timeout`  out  1  sticky watchdog flag.

## Operation
- Stall encoding is combinational from the requests. Only the highest-priority request takes effect:
  - `stallreq_mem`: 6'b011111
  - `stallreq_ex`: 6'b001111
  - `stallreq_id`: 6'b000111
  - `stallreq_if`: 6'b000011
  - none: 6'b000000
- Priority order is mem > ex > id > if. A stall boundary (bit k = 1, bit k+1 = 0) makes the downstream register insert a bubble.
- The state machine has two states, RUN and FLUSH.
- RUN:
  - `flush` = 0.
  - `excp_req` = 1 with `stallreq_mem` = 0 is accepted. In that cycle `stall` = 6'b111111, `excp_pc` is latched, and the next state is FLUSH.
  - `excp_req` while `stallreq_mem` = 1 is deferred (not latched). MEM must hold `excp_req` until accepted.
- FLUSH, exactly one cycle:
  - `flush` = 1, `new_pc` = latched PC, `stall` = 6'b000000.
  - All requests, including `excp_req`, are ignored.
  - Next state is RUN unconditionally.
- `new_pc` = 32'h0 whenever `flush` = 0.
- `stall_cycles`: +1 each cycle `stall` != 0, including the all-stop accept cycle. It saturates at 32'hFFFFFFFF.
- Watchdog:
  - A 16-bit run counter increments each cycle any `stallreq_*` is 1. It clears on any cycle with no request and during FLUSH.
  - When the counter reaches `TIMEOUT`, `stall_timeout` sets and stays set until reset. The run counter saturates at `TIMEOUT`.
  - The watchdog has no effect on `stall`.

## Timing
- Reset (synchronous, `resetn` = 1 at an edge): state RUN, latched PC 0, `stall_cycles` 0, run counter 0, `stall_timeout` 0.
- While `resetn` = 1, outputs read `stall` = 0, `flush` = 0, `new_pc` = 0. Reset overrides both the accept cycle and FLUSH.
- Latency: `stall` responds in the same cycle as the request (zero latency).
- Flush sequence:
  - Accept at edge N.
  - `flush` = 1 and `new_pc` valid during cycle N+1.
  - Normal operation resumes from cycle N+2.
- Simultaneous requests: priority encoding only, no accumulation.
- Simultaneous `excp_req` and `stallreq_ex`/`id`/`if` in RUN: the exception wins and the stall is 6'b111111.
- `stall_timeout` rises at the edge where the run counter reaches `TIMEOUT`. With `TIMEOUT` = 1 it rises after the first requested cycle.

## Test plan
- Reset, then idle 5 cycles: `stall` = 0, `flush` = 0, `new_pc` = 0, `stall_cycles` = 0, `stall_timeout` = 0.
- `stallreq_id` and `stallreq_ex` both high for 3 cycles: `stall` = 6'b001111 each cycle, then 0; `stall_cycles` = 3.
- `excp_req` = 1 with `excp_pc` = 32'h0000_0180 in RUN:
  - Accept cycle: `stall` = 6'b111111.
  - Next cycle: `flush` = 1, `new_pc` = 32'h0000_0180, `stall` = 0.
  - Cycle after: `flush` = 0.
- `excp_req` held while `stallreq_mem` = 1 for 4 cycles: no flush and `stall` = 6'b011111 throughout. Acceptance happens on the first cycle `stallreq_mem` = 0, and `flush` follows one cycle later.
- `TIMEOUT` = 8 with `stallreq_if` held 8 cycles: `stall_timeout` = 1 after the 8th edge and remains 1 after the request drops. Assert `resetn` for one edge: flag cleared.
- Assert `resetn` in the FLUSH cycle: the next cycle has `flush` = 0, `new_pc` = 0, state RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Stall and flush controller for the six-stage pipeline (PC, IF, ID, EX, MEM,
// WB). It priority-encodes per-stage stall requests into the shared stall
// vector, sequences exception redirects through a one-cycle FLUSH state, counts
// stalled cycles, and raises a sticky watchdog flag when stall requests persist
// for TIMEOUT consecutive cycles.
//
// Parameters:
//   TIMEOUT        consecutive requested-stall cycles that trip the watchdog
//                  (1..65535)
// Ports:
//   clk            system clock, rising edge
//   resetn         synchronous reset, active-high
//   stallreq_if    IF waiting on instruction fetch
//   stallreq_id    ID load-use hazard
//   stallreq_ex    EX multi-cycle operation busy
//   stallreq_mem   MEM waiting on data memory
//   excp_req       exception / redirect from MEM
//   excp_pc        redirect target, valid with excp_req
//   stall[5:0]     per-stage hold (bit0 PC .. bit5 WB), 1 = stop
//   flush          clear all pipeline registers this cycle
//   new_pc         PC to load while flush = 1, otherwise 0
//   stall_cycles   saturating count of cycles with stall != 0
//   stall_timeout  sticky watchdog flag
// -----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        excp_req,
   input  logic [31:0] excp_pc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles,
   output logic        stall_timeout
);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   state_t      state;
   logic [31:0] pc_q;
   logic [15:0] run_cnt;
   logic        any_req;
   logic        accept;

   assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

   // An exception is only taken when MEM is not itself stalled; otherwise the
   // faulting instruction has not finished and MEM keeps excp_req asserted.
   assign accept = (state == RUN) && excp_req && !stallreq_mem;

   // NOTE: every path through this block assigns stall because of the default
   // at the top, so no latch is inferred for the un-covered branches.
   always_comb begin
      stall = 6'b000000;
      if (!resetn && state == RUN) begin
         if (accept)            stall = 6'b111111;
         else if (stallreq_mem) stall = 6'b011111;
         else if (stallreq_ex)  stall = 6'b001111;
         else if (stallreq_id)  stall = 6'b000111;
         else if (stallreq_if)  stall = 6'b000011;
      end
   end

   // Reset forces the outputs quiet even while the state register still holds
   // FLUSH from before the reset edge.
   assign flush  = !resetn && (state == FLUSH);
   assign new_pc = flush ? pc_q : 32'h0;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (resetn) begin
         state         <= RUN;
         pc_q          <= 32'h0;
         stall_cycles  <= 32'h0;
         run_cnt       <= 16'h0;
         stall_timeout <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (accept) begin
                  state <= FLUSH;
                  pc_q  <= excp_pc;
               end
            end
            FLUSH:   state <= RUN;
            default: state <= RUN;
         endcase

         if (stall != 6'b000000 && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;

         // Watchdog: length of the current run of requested-stall cycles.
         // Requests are ignored during FLUSH, so the run restarts there.
         if (state == FLUSH || !any_req) begin
            run_cnt <= 16'h0;
         end else if (run_cnt != TIMEOUT_CNT) begin
            run_cnt <= run_cnt + 16'd1;
            if (run_cnt + 16'd1 == TIMEOUT_CNT)
               stall_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Scoreboard bench for pipe_ctrl. The stimulus process drives one set of
// inputs per cycle, advances a behavioural model and pushes the expected
// outputs for that cycle into a queue. A separate monitor pops one entry per
// cycle on the falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        stallreq_if = 1'b0, stallreq_id = 1'b0;
   logic        stallreq_ex = 1'b0, stallreq_mem = 1'b0;
   logic        excp_req = 1'b0;
   logic [31:0] excp_pc = 32'h0;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] stall_cycles;
   logic        stall_timeout;

   pipe_ctrl #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .stallreq_if  (stallreq_if),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .stallreq_mem (stallreq_mem),
      .excp_req     (excp_req),
      .excp_pc      (excp_pc),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .stall_cycles (stall_cycles),
      .stall_timeout(stall_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] new_pc;
      logic [31:0] cycles;
      logic        timeout;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Behavioural model state: "a flush is showing this cycle", the redirect
   // target, total stalled cycles, length of the current request run, flag.
   bit          m_flush = 0;
   logic [31:0] m_pc = 32'h0;
   longint      m_cycles = 0;
   int          m_run = 0;
   bit          m_to = 0;

   // Inputs and expected stall of the cycle just finished.
   bit          p_rst = 1, p_any = 0, p_acc = 0;
   logic [31:0] p_pc = 32'h0;
   logic [5:0]  p_stall = 6'h0;

   // Number of stages frozen = position of the requesting stage plus one
   // (the PC itself), so the stall vector is a run of that many low ones.
   function automatic logic [5:0] model_stall(bit rst, bit fl, bit i_if, bit i_id,
                                              bit i_ex, bit i_mem, bit exc);
      int depth;
      if (rst || fl) return 6'h00;
      if (exc && !i_mem) return 6'h3F;
      depth = i_mem ? 5 : i_ex ? 4 : i_id ? 3 : i_if ? 2 : 0;
      return 6'((1 << depth) - 1);
   endfunction

   task automatic model_advance();
      if (p_rst) begin
         m_flush = 0; m_pc = 32'h0; m_cycles = 0; m_run = 0; m_to = 0;
      end else if (m_flush) begin
         m_flush = 0;
         m_run   = 0;
      end else begin
         if (p_stall != 6'h0 && m_cycles < 64'hFFFF_FFFF) m_cycles++;
         if (p_any) begin
            m_run = (m_run + 1 > TO) ? TO : m_run + 1;
            if (m_run == TO) m_to = 1;
         end else begin
            m_run = 0;
         end
         if (p_acc) begin
            m_flush = 1;
            m_pc    = p_pc;
         end
      end
   endtask

   task automatic step(input bit rst, input bit i_if, input bit i_id, input bit i_ex,
                       input bit i_mem, input bit exc, input logic [31:0] pc);
      exp_t e;
      @(posedge clk);
      #1;
      model_advance();
      resetn       = rst;
      stallreq_if  = i_if;
      stallreq_id  = i_id;
      stallreq_ex  = i_ex;
      stallreq_mem = i_mem;
      excp_req     = exc;
      excp_pc      = pc;
      e.stall   = model_stall(rst, m_flush, i_if, i_id, i_ex, i_mem, exc);
      e.flush   = !rst && m_flush;
      e.new_pc  = e.flush ? m_pc : 32'h0;
      e.cycles  = 32'(m_cycles);
      e.timeout = m_to;
      exp_q.push_back(e);
      p_rst   = rst;
      p_any   = i_if | i_id | i_ex | i_mem;
      p_acc   = !rst && !m_flush && exc && !i_mem;
      p_pc    = pc;
      p_stall = e.stall;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   // Monitor: one comparison set per cycle whenever an expectation is queued.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("stall",         32'(stall),         32'(e.stall));
         check("flush",         32'(flush),         32'(e.flush));
         check("new_pc",        new_pc,             e.new_pc);
         check("stall_cycles",  stall_cycles,       e.cycles);
         check("stall_timeout", 32'(stall_timeout), 32'(e.timeout));
      end
   end

   initial begin
      // Bring the DUT out of X with reset held for two edges before checking.
      resetn = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      p_rst = 1;

      // Reset then idle.
      step(1, 0, 0, 0, 0, 0, 32'h0);
      idle(5);

      // ID + EX together: EX wins, no accumulation.
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0, 32'h0);
      idle(2);

      // Exception accepted in RUN, flush next cycle.
      step(0, 0, 0, 0, 0, 1, 32'h0000_0180);
      idle(3);

      // Exception held behind a MEM stall, then accepted once MEM frees.
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1, 32'h0000_0240);
      step(0, 0, 0, 0, 0, 1, 32'h0000_0240);
      idle(3);

      // Exception together with an EX stall: exception wins.
      step(0, 0, 0, 1, 0, 1, 32'hDEAD_BEE0);
      idle(2);

      // Watchdog: IF held TIMEOUT cycles trips the sticky flag.
      for (int i = 0; i < TO; i++) step(0, 1, 0, 0, 0, 0, 32'h0);
      idle(3);
      step(1, 0, 0, 0, 0, 0, 32'h0);
      idle(2);

      // One cycle short of the timeout must not trip it.
      for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 1, 0, 0, 32'h0);
      idle(2);

      // Reset asserted during the FLUSH cycle.
      step(0, 0, 0, 0, 0, 1, 32'h0000_0300);
      step(1, 0, 0, 0, 0, 0, 32'h0);
      idle(3);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) == 0), $urandom);
      end
      idle(2);

      @(posedge clk);
      @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
